// File: rtl/rv32_pkg.sv
// Shared RV32I_X core types and constants used by the fetch path.
package rv32_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ILEN      = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } ifu_state_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/rv32_ifu_fifo.sv
// Synchronous FIFO of fetch entries with a registered head that holds its last value when empty.
module rv32_ifu_fifo
  import rv32_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  fetch_entry_t               i_push_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [$clog2(DEPTH):0]     o_occ,
  output fetch_entry_t               o_head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  fetch_entry_t   r_mem [DEPTH];
  fetch_entry_t   r_head;
  fetch_entry_t   w_head_nxt;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [OW-1:0]  r_occ;
  logic           w_wr;
  logic           w_rd;

  assign w_wr = i_push & ~i_flush;
  assign w_rd = i_pop & ~i_flush;

  // The head register looks one entry ahead so decode sees a flopped value every cycle.
  always_comb begin
    w_head_nxt = r_head;
    if (w_rd) begin
      if (r_occ > OW'(1))
        w_head_nxt = r_mem[r_rd_ptr + AW'(1)];
      else if (w_wr)
        w_head_nxt = i_push_data;
    end else if (r_occ == '0 && w_wr) begin
      w_head_nxt = i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_head   <= '0;
    end else begin
      r_head <= w_head_nxt;
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_occ    <= '0;
      end else begin
        if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
        r_occ <= r_occ + OW'(w_wr) - OW'(w_rd);
      end
    end
  end

  assign o_occ  = r_occ;
  assign o_head = r_head;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_wr && !w_rd && r_occ == OW'(DEPTH)));

endmodule

// File: rtl/rv32_ifu.sv
// RV32I_X instruction fetch unit: credit-gated sequential ICCM fetch feeding decode through a small FIFO.
module rv32_ifu
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] iccm_rd_addr,
  output logic        iccm_rden,
  input  logic [31:0] iccm_rd_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        dec_ready,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc
);

  localparam int unsigned OW = $clog2(FIFO_DEPTH) + 1;

  ifu_state_t     r_state;
  logic [31:0]    r_fetch_pc;
  logic           r_inflight;
  logic [31:0]    r_inflight_pc;

  logic [OW-1:0]  w_occ;
  logic [OW:0]    w_need;
  fetch_entry_t   w_head;
  fetch_entry_t   w_push_data;
  logic           w_pop;
  logic           w_push;
  logic           w_issue;

  assign dec_valid = (w_occ != '0) & ~redirect_valid;
  assign w_pop     = dec_valid & dec_ready;

  // Credits count buffered entries left after this cycle's pop plus the read still in flight.
  assign w_need  = {1'b0, w_occ} - (OW+1)'(w_pop) + (OW+1)'(r_inflight);
  assign w_issue = (r_state == ST_RUN) & ~redirect_valid & (w_need < (OW+1)'(FIFO_DEPTH));

  assign iccm_rden    = w_issue;
  assign iccm_rd_addr = r_fetch_pc;

  assign w_push            = r_inflight & ~redirect_valid;
  assign w_push_data.pc    = r_inflight_pc;
  assign w_push_data.instr = iccm_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BOOT;
      r_fetch_pc    <= align_word(RESET_PC);
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        default: r_state <= ST_RUN;
      endcase
      if (redirect_valid)
        r_fetch_pc <= align_word(redirect_pc);
      else if (w_issue)
        r_fetch_pc <= r_fetch_pc + 32'd4;
      r_inflight <= w_issue;
      if (w_issue)
        r_inflight_pc <= r_fetch_pc;
    end
  end

  rv32_ifu_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_occ       (w_occ),
    .o_head      (w_head)
  );

  assign dec_instr = w_head.instr;
  assign dec_pc    = w_head.pc;

endmodule

// File: tb/tb_rv32_ifu.sv
// Directed bench for rv32_ifu: per-cycle vector table plus hand sequences for async reset.
module tb_rv32_ifu;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] iccm_rd_addr;
  logic        iccm_rden;
  logic [31:0] iccm_rd_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv32_ifu #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .iccm_rd_addr   (iccm_rd_addr),
    .iccm_rden      (iccm_rden),
    .iccm_rd_data   (iccm_rd_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_ready      (dec_ready),
    .dec_valid      (dec_valid),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc)
  );

  // ICCM model: one-cycle synchronous read returning a known function of the address.
  always @(posedge clk) begin
    if (iccm_rden) iccm_rd_data <= iccm_rd_addr ^ KEY;
  end

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_rden;
    logic [31:0] e_addr;
    logic        e_dv;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy,
                     input logic e_rden, input logic [31:0] e_addr, input logic e_dv,
                     input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.e_rden = e_rden; v.e_addr = e_addr; v.e_dv = e_dv; v.e_pc = e_pc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    int first;

    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b1;

    //   rst rv rpc           rdy  rden addr          dv  dec_pc
    add(1, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0);
    add(1, 0, 32'h0,        1,   1, 32'h0,        0, 32'h0);
    add(1, 0, 32'h0,        1,   1, 32'h4,        0, 32'h0);
    add(1, 0, 32'h0,        1,   1, 32'h8,        1, 32'h0);
    add(1, 0, 32'h0,        1,   1, 32'hC,        1, 32'h4);
    add(1, 0, 32'h0,        1,   1, 32'h10,       1, 32'h8);
    for (int i = 0; i < 5; i++)
      add(1, 0, 32'h0,      0,   0, 32'h14,       1, 32'hC);
    add(1, 0, 32'h0,        1,   1, 32'h14,       1, 32'hC);
    add(1, 0, 32'h0,        1,   1, 32'h18,       1, 32'h10);
    add(1, 0, 32'h0,        1,   1, 32'h1C,       1, 32'h14);
    add(1, 0, 32'h0,        1,   1, 32'h20,       1, 32'h18);
    add(1, 0, 32'h0,        1,   1, 32'h24,       1, 32'h1C);
    add(1, 1, 32'h104,      1,   0, 32'h28,       0, 32'h20);
    add(1, 0, 32'h0,        1,   1, 32'h104,      0, 32'h20);
    add(1, 0, 32'h0,        1,   1, 32'h108,      0, 32'h20);
    add(1, 0, 32'h0,        1,   1, 32'h10C,      1, 32'h104);
    add(1, 0, 32'h0,        1,   1, 32'h110,      1, 32'h108);
    add(1, 1, 32'h203,      1,   0, 32'h114,      0, 32'h10C);
    add(1, 0, 32'h0,        1,   1, 32'h200,      0, 32'h10C);
    add(1, 0, 32'h0,        1,   1, 32'h204,      0, 32'h10C);
    add(1, 0, 32'h0,        1,   1, 32'h208,      1, 32'h200);
    add(1, 1, 32'hFFFF_FFFC, 1,  0, 32'h20C,      0, 32'h204);
    add(1, 0, 32'h0,        1,   1, 32'hFFFF_FFFC, 0, 32'h204);
    add(1, 0, 32'h0,        1,   1, 32'h0,        0, 32'h204);
    add(1, 0, 32'h0,        1,   1, 32'h4,        1, 32'hFFFF_FFFC);
    add(1, 0, 32'h0,        1,   1, 32'h8,        1, 32'h0);
    add(1, 0, 32'h0,        1,   1, 32'hC,        1, 32'h4);
    add(0, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0);
    add(0, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0);
    add(1, 1, 32'h40,       1,   0, 32'h0,        0, 32'h0);
    add(1, 0, 32'h0,        1,   1, 32'h40,       0, 32'h0);
    add(1, 0, 32'h0,        1,   1, 32'h44,       0, 32'h0);
    add(1, 0, 32'h0,        1,   1, 32'h48,       1, 32'h40);
    add(1, 0, 32'h0,        1,   1, 32'h4C,       1, 32'h44);

    repeat (3) @(negedge clk);

    foreach (tbl[i]) begin
      if (i != 0) @(negedge clk);
      rst_n          = tbl[i].rst;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      dec_ready      = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d rden", i),  {31'b0, iccm_rden}, {31'b0, tbl[i].e_rden});
      if (tbl[i].e_rden || !tbl[i].rst)
        chk($sformatf("row%0d addr", i), iccm_rd_addr, tbl[i].e_addr);
      chk($sformatf("row%0d dv", i),    {31'b0, dec_valid}, {31'b0, tbl[i].e_dv});
      chk($sformatf("row%0d dec_pc", i), dec_pc, tbl[i].e_pc);
      if (tbl[i].e_dv)
        chk($sformatf("row%0d dec_instr", i), dec_instr, tbl[i].e_pc ^ KEY);
    end

    // Reset asserted between edges mid-stream must clear outputs before the next clock.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rden",  {31'b0, iccm_rden}, 32'h0);
    chk("async addr",  iccm_rd_addr, 32'h0);
    chk("async dv",    {31'b0, dec_valid}, 32'h0);
    chk("async pc",    dec_pc, 32'h0);
    chk("async instr", dec_instr, 32'h0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; redirect_valid = 1'b0; dec_ready = 1'b1;
    #1;
    chk("restart boot rden", {31'b0, iccm_rden}, 32'h0);
    first = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      #1;
      if (cyc == 1) begin
        chk("restart rden", {31'b0, iccm_rden}, 32'h1);
        chk("restart addr", iccm_rd_addr, 32'h0);
      end
      if (dec_valid) begin
        first = cyc;
        break;
      end
    end
    chk("restart first dv cycle", first, 3);
    chk("restart dec_pc", dec_pc, 32'h0);
    chk("restart dec_instr", dec_instr, KEY);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
